// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared axis state type and default 640x480@60 timing values
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

endpackage

// File: rtl/vga_axis_timer.sv
// rtl/vga_axis_timer.sv - one raster axis: phase FSM plus position counter
// count_o is registered; state_o is the next-state value so the parent can register decodes in step.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               step_i,
  output logic [COUNT_W-1:0] count_o,
  output logic [1:0]         state_o,
  output logic               wrap_o
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  function automatic logic [COUNT_W-1:0] state_len(axis_state_t s);
    case (s)
      ACTIVE:  return COUNT_W'(ACTIVE_LEN);
      FRONT:   return COUNT_W'(FRONT_LEN);
      SYNC:    return COUNT_W'(SYNC_LEN);
      default: return COUNT_W'(BACK_LEN);
    endcase
  endfunction

  function automatic logic [COUNT_W-1:0] state_base(axis_state_t s);
    case (s)
      ACTIVE:  return '0;
      FRONT:   return COUNT_W'(ACTIVE_LEN);
      SYNC:    return COUNT_W'(ACTIVE_LEN + FRONT_LEN);
      default: return COUNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
    endcase
  endfunction

  function automatic axis_state_t state_next(axis_state_t s);
    case (s)
      ACTIVE:  return FRONT;
      FRONT:   return SYNC;
      SYNC:    return BACK;
      default: return ACTIVE;
    endcase
  endfunction

  axis_state_t        state_q, state_d;
  logic [COUNT_W-1:0] pos_q, pos_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               last;

  // pos_q is the offset inside the current phase; the raster count is base + offset.
  always_comb begin
    last    = (pos_q == state_len(state_q) - ONE);
    state_d = state_q;
    pos_d   = pos_q;
    if (step_i) begin
      if (last) begin
        state_d = state_next(state_q);
        pos_d   = '0;
      end else begin
        pos_d = pos_q + ONE;
      end
    end
    count_d = state_base(state_d) + pos_d;
    wrap_o  = step_i && last && (state_q == BACK);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ACTIVE;
      pos_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign state_o = state_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator stepped by a pixel enable on the fast clock
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  logic       h_wrap, v_wrap, v_step;
  logic [1:0] h_state_d, v_state_d;
  logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  assign v_step = pix_en && h_wrap;

  vga_axis_timer #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h (
    .clk_in (clk_in),
    .reset  (reset),
    .step_i (pix_en),
    .count_o(pixel_x),
    .state_o(h_state_d),
    .wrap_o (h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v (
    .clk_in (clk_in),
    .reset  (reset),
    .step_i (v_step),
    .count_o(pixel_y),
    .state_o(v_state_d),
    .wrap_o (v_wrap)
  );

  // Decodes use the next-state phases so they line up with the counters they describe.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (h_state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= (v_state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= (h_state_d == ACTIVE) && (v_state_d == ACTIVE);
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: full-size and shrunk-timing instances driven in lockstep
module tb_vga_timing_gen;

  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    string nm;
    int    sel;
    int    val;
  } dir_t;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       pix_en = 1'b0;

  logic       hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, vid_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  always #5 clk_in = ~clk_in;

  vga_timing_gen dut_b (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
    .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk_in(clk_in), .reset(reset), .pix_en(pix_en),
    .hsync(hs_s), .vsync(vs_s), .video_on(vid_s),
    .pixel_x(x_s), .pixel_y(y_s), .line_start(ls_s), .frame_start(fs_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  obs_t qb[$];
  obs_t qs[$];
  int   qp[$];
  dir_t dq[$];

  int bh = 0, bv = 0, sh = 0, sv = 0;
  int ph = 0;

  int cnt_ls_b = 0, cnt_fs_b = 0, cnt_fs_s = 0, cnt_hold = 0;
  int per_hs_b[$];
  int per_fs_s[$];
  int per_hs_s[$];
  int cyc = 0;
  int last_hs_b = -1, last_fs_s = -1, last_hs_s = -1;
  logic prev_hs_b = 1'b1, prev_hs_s = 1'b0;

  function automatic void chk(string nm, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endfunction

  function automatic void cmp_obs(string nm, obs_t a, obs_t e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s @cyc %0d: got x=%0d y=%0d hs=%b vs=%b vid=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b vid=%b ls=%b fs=%b",
                 nm, cyc, a.x, a.y, a.hs, a.vs, a.vid, a.ls, a.fs,
                 e.x, e.y, e.hs, e.vs, e.vid, e.ls, e.fs);
    end
  endfunction

  function automatic int get_sig(int sel);
    case (sel)
      0:  return int'(x_b);
      1:  return int'(y_b);
      2:  return int'(hs_b);
      3:  return int'(vs_b);
      4:  return int'(vid_b);
      5:  return int'(ls_b);
      6:  return int'(fs_b);
      7:  return int'(x_s);
      8:  return int'(y_s);
      9:  return int'(hs_s);
      10: return int'(vs_s);
      11: return int'(vid_s);
      12: return int'(ls_s);
      default: return int'(fs_s);
    endcase
  endfunction

  // Reference raster model built from the decode equations, not from the FSM structure.
  task automatic model_step(inout int h, inout int v, input logic en, input logic rst,
                            input int ha, input int hf, input int hsw, input int hb,
                            input int va, input int vf, input int vsw, input int vb,
                            input logic pol, output obs_t o);
    int ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    o.ls = 1'b0;
    o.fs = 1'b0;
    if (rst) begin
      h = 0;
      v = 0;
    end else if (en) begin
      o.ls = (h == ht - 1);
      o.fs = o.ls && (v == vt - 1);
      if (o.ls) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
    end
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.vid = (h < ha) && (v < va);
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
  endtask

  task automatic tick(input logic en, input logic rst);
    obs_t eb, es;
    pix_en = en;
    reset  = rst;
    @(posedge clk_in);
    #1;
    model_step(bh, bv, en, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, eb);
    model_step(sh, sv, en, rst, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1, es);
    qb.push_back(eb);
    qs.push_back(es);
    qp.push_back(ph);
  endtask

  function automatic void expect_d(string nm, int sel, int val);
    dir_t d;
    d.nm  = nm;
    d.sel = sel;
    d.val = val;
    dq.push_back(d);
  endfunction

  always @(negedge clk_in) begin
    obs_t eb, es, ab, as_;
    dir_t d;
    int   p;
    cyc++;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      es = qs.pop_front();
      p  = qp.pop_front();
      ab = '{x: x_b, y: y_b, hs: hs_b, vs: vs_b, vid: vid_b, ls: ls_b, fs: fs_b};
      as_ = '{x: x_s, y: y_s, hs: hs_s, vs: vs_s, vid: vid_s, ls: ls_s, fs: fs_s};
      cmp_obs("raster_640x480", ab, eb);
      cmp_obs("raster_small", as_, es);
      if (p == 2) begin
        cnt_ls_b += int'(ls_b);
        cnt_fs_b += int'(fs_b);
        cnt_fs_s += int'(fs_s);
      end
      if (p == 4) cnt_hold += int'(ls_b) + int'(fs_b) + int'(ls_s) + int'(fs_s);
      if (p == 5) begin
        if (prev_hs_b && !hs_b) begin
          if (last_hs_b >= 0) per_hs_b.push_back(cyc - last_hs_b);
          last_hs_b = cyc;
        end
        if (!prev_hs_s && hs_s) begin
          if (last_hs_s >= 0) per_hs_s.push_back(cyc - last_hs_s);
          last_hs_s = cyc;
        end
        if (fs_s) begin
          if (last_fs_s >= 0) per_fs_s.push_back(cyc - last_fs_s);
          last_fs_s = cyc;
        end
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      chk(d.nm, get_sig(d.sel), d.val);
    end
    prev_hs_b = hs_b;
    prev_hs_s = hs_s;
  end

  initial begin
    ph = 1;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    expect_d("reset_x", 0, 0);
    expect_d("reset_y", 1, 0);
    expect_d("reset_hsync", 2, 1);
    expect_d("reset_vsync", 3, 1);
    expect_d("reset_video_on", 4, 1);
    expect_d("reset_line_start", 5, 0);
    expect_d("reset_small_hsync", 9, 0);
    expect_d("reset_small_vsync", 10, 0);

    ph = 2;
    for (int i = 1; i <= 801; i++) begin
      tick(1'b1, 1'b0);
      case (i)
        8:   expect_d("small_video_off_x8", 11, 0);
        10:  begin expect_d("small_x10", 7, 10); expect_d("small_hsync_on", 9, 1); end
        75:  begin expect_d("small_y5", 8, 5); expect_d("small_vsync_on", 10, 1); end
        105: begin expect_d("small_y7", 8, 7); expect_d("small_vsync_off", 10, 0); end
        120: begin expect_d("small_frame_start", 13, 1); expect_d("small_wrap_y", 8, 0); end
        121: expect_d("small_frame_start_end", 13, 0);
        639: expect_d("video_on_x639", 4, 1);
        640: begin expect_d("video_off_x640", 4, 0); expect_d("x640", 0, 640); end
        655: expect_d("hsync_idle_x655", 2, 1);
        656: begin expect_d("hsync_on_x656", 2, 0); expect_d("x656", 0, 656); end
        751: expect_d("hsync_on_x751", 2, 0);
        752: begin expect_d("hsync_off_x752", 2, 1); expect_d("x752", 0, 752); end
        799: begin expect_d("x799", 0, 799); expect_d("no_line_start_x799", 5, 0); end
        800: begin
          expect_d("wrap_x", 0, 0);
          expect_d("wrap_y", 1, 1);
          expect_d("line_start", 5, 1);
          expect_d("video_on_line1", 4, 1);
          expect_d("no_frame_start", 6, 0);
        end
        801: expect_d("line_start_one_cycle", 5, 0);
        default: ;
      endcase
    end

    ph = 3;
    for (int i = 0; i < 299; i++) tick(1'b1, 1'b0);
    ph = 4;
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
    expect_d("hold_x", 0, 300);
    expect_d("hold_y", 1, 1);

    ph = 3;
    tick(1'b1, 1'b1);
    expect_d("midreset_x", 0, 0);
    expect_d("midreset_y", 1, 0);
    expect_d("midreset_hsync", 2, 1);
    expect_d("midreset_vsync", 3, 1);
    expect_d("midreset_video_on", 4, 1);
    expect_d("midreset_small_x", 7, 0);

    ph = 5;
    for (int k = 0; k < 5000; k++) tick(k % 2 == 1, 1'b0);

    ph = 6;
    @(negedge clk_in);
    #1;

    chk("line_start_pulses_first_line", cnt_ls_b, 1);
    chk("frame_start_pulses_first_line", cnt_fs_b, 0);
    chk("small_frame_starts_first_801", cnt_fs_s, 6);
    chk("pulses_during_hold", cnt_hold, 0);
    chk("hsync_period_samples", int'(per_hs_b.size() >= 2), 1);
    foreach (per_hs_b[i]) chk("hsync_period_cycles", per_hs_b[i], 1600);
    chk("small_frame_period_samples", int'(per_fs_s.size() >= 2), 1);
    foreach (per_fs_s[i]) chk("small_frame_period_cycles", per_fs_s[i], 240);
    chk("small_hsync_period_samples", int'(per_hs_s.size() >= 2), 1);
    foreach (per_hs_s[i]) chk("small_hsync_period_cycles", per_hs_s[i], 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 25 MHz pixel-rate enable produced from the 50 MHz board clock and generates 640x480@60 VGA raster timing: hsync, vsync, video_on, and the current pixel coordinate.
- Sits between the clock divider and the pixel/colour logic that drives the VGA DAC.
- Clocked on the fast clock; advances one pixel per pix_en pulse. It does not use the divided clock as a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk_in  input  1  system clock (50 MHz); single clock domain
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel advance enable, one clk_in cycle wide (every 2nd cycle from divider)
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- video_on  output  1  high when the current pixel is in the visible area
- pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  current vertical count, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when h wraps to 0
- frame_start  output  1  one-cycle pulse when (h,v) wraps to (0,0)

Behaviour:
- Clock and reset: one clock (clk_in); reset is synchronous and active-high. Reset takes priority over pix_en.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Counters are 10-bit unsigned.
- Reset values: h=0, v=0, pixel_x=0, pixel_y=0, video_on=1, hsync=vsync=~SYNC_POL, line_start=0, frame_start=0.
- Counter advance, on a clk_in edge with pix_en=1:
  - h increments.
  - At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At v=V_TOTAL-1 together with an h wrap, v wraps to 0.
- With pix_en=0, all counters and level outputs hold; line_start and frame_start are 0.
- All outputs are registered and decoded from the next-state counter values, so they describe the updated (h,v) in the same cycle the counters change. There is no extra pipeline latency.
- Decode:
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync asserted for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync asserted for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 490..491, for the whole line.
  - pixel_x = h and pixel_y = v (raw counts; consumers gate with video_on).
- Per-axis FSM with states ACTIVE, FRONT, SYNC, BACK:
  - ACTIVE leaves at count ACTIVE-1; FRONT, SYNC and BACK each leave at their last count in the same way.
  - BACK returns to ACTIVE on wrap.
  - The horizontal FSM steps on pix_en. The vertical FSM steps only on the horizontal wrap.
  - sync and video_on are derived from the FSM state; the counter is the position within the current state plus a base offset.
- Pulses:
  - line_start = 1 for exactly the clk_in cycle following the edge where h wrapped.
  - frame_start additionally requires v to have wrapped.
- pix_en held continuously high is legal: the block counts every cycle, with no dropped or doubled pixels.
- Reset mid-frame: the next edge returns to reset values regardless of pix_en. No partial sync pulse is extended.

Decomposition:
- Package vga_timing_pkg contains:
  - typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t
  - localparam defaults for the 640x480 timing values
  - localparam COUNT_W = 10
- Sub-module vga_axis_timer:
  - One counter plus one axis_state_t FSM, parameterised by ACTIVE/FRONT/SYNC/BACK.
  - Inputs: step. Outputs: count, state, wrap.
  - Instantiated twice: horizontal with step=pix_en; vertical with step=pix_en && h_wrap.

Test Plan:
- Reset, then 800 pix_en pulses -> pixel_x=0, pixel_y=1; line_start high for exactly 1 cycle; frame_start stays 0.
- From reset, 656 pix_en -> hsync=0 (pixel_x=656); after 96 more -> hsync=1 (pixel_x=752); video_on=0 from pixel_x=640.
- 420000 pix_en (one full frame) -> vsync low from pixel_y=490,x=0 through pixel_y=491,x=799 (1600 ticks); frame_start exactly once at return to (0,0).
- Mid-line (x=300), hold pix_en=0 for 100 clk_in cycles -> every output unchanged, no pulses.
- Reset asserted at x=300,y=200 with pix_en=1 -> next cycle x=0, y=0, hsync=vsync=1, video_on=1.
- pix_en alternating 0/1 (divider pattern) for 2 frames -> frame_start period exactly 840000 clk_in cycles; hsync period 1600 cycles.
